// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: sequencing controller for the 5-stage MIPS pipeline.
// Produces load-enable and bubble-insert controls for the PC and the four
// inter-stage registers. Events are resolved in priority order: syscall halt,
// multi-cycle memory wait, taken-branch squash, load-use stall. The block also
// keeps cycle/stall/squash statistics for the debug display.
module pipe_stage_ctrl #(
    parameter int MEM_LAT   = 1,   // data-memory latency in cycles, 1..16
    parameter int CNT_WIDTH = 32   // statistics counter width
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 mem_access,
    input  logic                 load_use,
    input  logic                 branch_taken,
    input  logic                 halt_req,
    input  logic                 go,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 exmem_flush,
    output logic                 memwb_flush,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    // Enables ordered {pc, ifid, idex, exmem, memwb}; flushes {ifid, idex, exmem, memwb}.
    typedef struct packed {
        logic [4:0] en;
        logic [3:0] fl;
        logic       squash;
    } ctrl_t;

    // A latency of 1 needs no stall; otherwise the first stall cycle is spent
    // in RUN, so the counter is loaded with the number of extra wait cycles.
    localparam bit         MEM_STALL_EN = (MEM_LAT > 1);
    localparam int         WAIT_INIT_I  = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
    localparam logic [3:0] WAIT_INIT    = WAIT_INIT_I[3:0];

    // Freeze everything up to EX/MEM while WB receives a bubble.
    localparam ctrl_t CTRL_MEM_STALL = '{en: 5'b00001, fl: 4'b0001, squash: 1'b0};
    localparam ctrl_t CTRL_FROZEN    = '{en: 5'b00000, fl: 4'b0000, squash: 1'b0};
    localparam ctrl_t CTRL_DRAIN     = '{en: 5'b11111, fl: 4'b1111, squash: 1'b0};

    state_e               state_q, state_d;
    logic [3:0]           wait_q, wait_d;
    logic                 halted_q, halted_d;
    logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    ctrl_t                ctrl;

    // Advance-cycle resolution shared by RUN and the MEM_WAIT advance cycle.
    function automatic ctrl_t advance_ctrl(input logic br, input logic lu);
        ctrl_t c;
        if (br) begin
            // The load-use consumer sits in IF/ID and is squashed anyway.
            c = '{en: 5'b11111, fl: 4'b1100, squash: 1'b1};
        end else if (lu) begin
            c = '{en: 5'b00111, fl: 4'b0100, squash: 1'b0};
        end else begin
            c = '{en: 5'b11111, fl: 4'b0000, squash: 1'b0};
        end
        return c;
    endfunction

    // State register, wait counter, halted flag and statistics counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (clr) begin
            state_q     <= RUN;
            wait_q      <= 4'd0;
            halted_q    <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            halted_q    <= halted_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (mem_access && MEM_STALL_EN) begin
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_INIT;
                end
            end
            MEM_WAIT: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    state_d = RUN;
                end
            end
            HALT: begin
                if (go) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = 4'd0;
            end
        endcase
        halted_d = (state_d == HALT);
    end

    // Pipeline control outputs from state and inputs; clr forces a full drain.
    always_comb begin
        ctrl = CTRL_FROZEN;
        if (clr) begin
            ctrl = CTRL_DRAIN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (halt_req) begin
                        ctrl = CTRL_MEM_STALL;
                    end else if (mem_access && MEM_STALL_EN) begin
                        ctrl = CTRL_MEM_STALL;
                    end else begin
                        ctrl = advance_ctrl(branch_taken, load_use);
                    end
                end
                MEM_WAIT: begin
                    // mem_access is not re-examined on the advance cycle.
                    if (wait_q != 4'd0) begin
                        ctrl = CTRL_MEM_STALL;
                    end else begin
                        ctrl = advance_ctrl(branch_taken, load_use);
                    end
                end
                HALT:    ctrl = CTRL_FROZEN;
                default: ctrl = CTRL_FROZEN;
            endcase
        end
    end

    // Statistics: counted at the edge that ends the cycle; HALT cycles are not counted.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != HALT) begin
            cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
            if (!ctrl.en[4]) begin
                stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
            end
        end
        if (ctrl.squash) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en}  = ctrl.en;
    assign {ifid_flush, idex_flush, exmem_flush, memwb_flush} = ctrl.fl;
    assign halted    = halted_q;
    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_stage_ctrl.md
# pipe_stage_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Drives the load-enable and bubble-insert (flush) controls of the PC register and the four inter-stage pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves four conditions in priority order:

- syscall halt
- multi-cycle data-memory wait
- taken-branch squash
- load-use stall

It also keeps cycle, stall and flush statistics for the debug display.

## Interface

Parameters:

- MEM_LAT, default 1: data-memory access latency in cycles, valid range 1..16. A value of 1 means no memory stall.
- CNT_WIDTH, default 32: width of the statistics counters.

Ports:

- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset; synchronous, active-high.
- mem_access  in  1  the EX/MEM stage holds a lw or sw.
- load_use  in  1  a lw in ID/EX writes a register read by the instruction in IF/ID.
- branch_taken  in  1  a branch or jump resolved taken in EX.
- halt_req  in  1  a halting syscall is in MEM/WB, i.e. it is retiring this cycle.
- go  in  1  resume pulse from the front panel.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  load enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  bubble insert. When a flush is high and the matching enable is high, the stage loads all-zero (nop) at the next edge. Flushes drive the stage Data_in mux, not the register's asynchronous clear.
- halted  out  1  registered; high while in state HALT.
- cycle_cnt  out  CNT_WIDTH  non-halted cycle count.
- stall_cnt  out  CNT_WIDTH  stalled cycle count.
- flush_cnt  out  CNT_WIDTH  branch squash count.

## Operation

States: RUN, MEM_WAIT, HALT. A wait counter of 4 bits holds the remaining memory-wait cycles.

Outputs are combinational from state and inputs, evaluated in RUN by the following priority:

1. halt_req=1:
   - memwb_en=1 and memwb_flush=1; all other enables 0.
   - Next state HALT.
2. mem_access=1 and MEM_LAT>1:
   - pc, ifid, idex and exmem enables 0; memwb_en=1 and memwb_flush=1.
   - wait <= MEM_LAT-2; next state MEM_WAIT.
3. branch_taken=1:
   - All enables 1; ifid_flush=1 and idex_flush=1.
   - load_use is ignored, because its consumer is squashed.
4. load_use=1:
   - pc_en=0 and ifid_en=0.
   - idex_en=1 and idex_flush=1.
   - exmem_en=1 and memwb_en=1.
5. Otherwise: all enables 1, all flushes 0.

MEM_WAIT:

- wait>0: same outputs as rule 2; wait decrements.
- wait==0: this is the advance cycle. Apply rules 3–5 exactly as in RUN; mem_access is not re-examined. Next state RUN.
- halt_req is ignored, because WB holds a bubble.

HALT:

- All enables 0, flushes 0.
- go=1: next state RUN, which resumes with the frozen contents.
- halt_req is ignored in HALT.
- go is ignored outside HALT.

Counters (all wrap modulo 2^CNT_WIDTH; no saturation):

- cycle_cnt increments every cycle not in HALT.
- stall_cnt increments on every non-HALT cycle with pc_en=0, including the halt-entry cycle.
- flush_cnt increments on every cycle where rule 3 fires.

Reset:

- While clr=1: all enables 1 and all flushes 1, so every stage loads a nop and the pipe drains to bubbles.
- Next state RUN; wait=0; halted=0; all counters 0.
- clr overrides every input in every state, including mid-MEM_WAIT and HALT.

## Timing

- Load-use stall: exactly 1 cycle.
- Branch squash: 2 bubbles, no stall cycle.
- Memory access: exactly MEM_LAT-1 stalled cycles, then advance on cycle MEM_LAT. With MEM_LAT=1 there is never a stall and MEM_WAIT is never entered.
- Halt: the syscall retires on the edge it is seen. halted rises at the following edge. After go is sampled, RUN and full advance resume on the next cycle.
- Simultaneous mem_access and branch_taken in RUN: the memory stall wins. The squash is applied on the MEM_WAIT advance cycle, because branch_taken is held by the frozen EX stage.
- halted is the only registered output. The counters are registers that update at the edge ending the counted cycle.

## Test plan

- Reset: hold clr 2 cycles with random inputs. Required: all en=1, all flush=1 during clr. After release: halted=0, counters=0, plain advance with no flushes.
- Load-use: pulse load_use for 1 cycle. Required: pc_en=ifid_en=0 and idex_flush=1 for exactly 1 cycle; stall_cnt=1; cycle_cnt unaffected by the stall.
- Branch: branch_taken and load_use both high for 1 cycle. Required: all en=1, ifid_flush=idex_flush=1, pc_en=1; flush_cnt=1; stall_cnt=0.
- Memory wait: MEM_LAT=4, mem_access held high. Required: 3 stalled cycles with memwb_flush=1, full advance on the 4th cycle, then return to RUN; stall_cnt=3.
- Halt/resume: halt_req for 1 cycle, go asserted 5 cycles later. Required: halted high for 5 cycles, all enables 0 during HALT, cycle_cnt frozen, advance on the cycle after go. A second go while in RUN has no effect.
- Wrap and reset mid-operation: CNT_WIDTH=4, run 17 cycles. Required: cycle_cnt=1. Then assert clr during MEM_WAIT. Required: state RUN, wait cleared, pipe loads bubbles.
